// File: rtl/seq_ripple_adder.sv
// Multi-cycle ripple adder: adds two WIDTH-bit operands CHUNK bits per clock behind a start/busy/done handshake.
// Optional subtract mode (a-b, sum[WIDTH] = borrow) is enabled by defining SEQ_ADDER_SUB_EN.
module seq_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             done_q, done_d;

    logic             sub_in;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] s_ext;

`ifdef SEQ_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        sub_d     = sub_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        done_d    = 1'b0;

        chunk_sum = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        s_ext     = WIDTH'(chunk_sum[CHUNK-1:0]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B and seed the carry.
                    opa_d   = a;
                    opb_d   = sub_in ? ~b : b;
                    carry_d = sub_in;
                    sub_d   = sub_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                acc_d   = (acc_q >> CHUNK) | (s_ext << (WIDTH - CHUNK));
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    // Borrow is the inverted carry-out in subtract mode.
                    sum_d   = {chunk_sum[CHUNK] ^ sub_q, acc_d};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Scoreboard bench for seq_ripple_adder: three instances (CHUNK=4, 16, 1), directed vectors,
// a negedge monitor checking each done against queued expected sum and completion edge.
module tb_seq_ripple_adder;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [15:0] a, b;
    logic        sub_s;
    logic [2:0]  start_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [16:0] sum0, sum1, sum2;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cnt [3];

    typedef struct {
        int          id;
        logic [16:0] sum;
        int          at_edge;
    } exp_t;
    exp_t sb[$];

    seq_ripple_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum0)
    );

    seq_ripple_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum1)
    );

    seq_ripple_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub_s),
`endif
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum2)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] get_sum(input int k);
        case (k)
            0:       return sum0;
            1:       return sum1;
            default: return sum2;
        endcase
    endfunction

    function automatic int n_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation for that instance.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_v[k] === 1'b1) begin
                int idx;
                idx = -1;
                done_cnt[k]++;
                for (int i = 0; i < sb.size(); i++) begin
                    if (idx < 0 && sb[i].id == k) idx = i;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_done dut%0d: got done with sum 0x%0h expected no done", k, get_sum(k));
                end else begin
                    checks++;
                    if (get_sum(k) !== sb[idx].sum) begin
                        errors++;
                        $display("FAIL sum dut%0d: got 0x%0h expected 0x%0h", k, get_sum(k), sb[idx].sum);
                    end
                    if (cyc != sb[idx].at_edge) begin
                        errors++;
                        $display("FAIL done_edge dut%0d: got edge %0d expected edge %0d", k, cyc, sb[idx].at_edge);
                    end
                    sb.delete(idx);
                end
            end
        end
    end

    // Drives one start pulse from idle; returns 1 time unit after the accepting edge.
    task automatic issue(input int k, input logic [15:0] ea, input logic [15:0] eb,
                         input logic esub, input logic [16:0] exp_sum, input bit track);
        exp_t e;
        @(negedge clk);
        a          = ea;
        b          = eb;
        sub_s      = esub;
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        check($sformatf("busy_after_accept dut%0d", k), 32'(busy_v[k]), 32'd1);
        if (track) begin
            e.id      = k;
            e.sum     = exp_sum;
            e.at_edge = cyc + n_of(k);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_v[k] === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout dut%0d: got no done within %0d cycles expected done", k, budget);
    endtask

    initial begin
        int bc;
        int dc;
        bit seen;
        clk_en  = 1'b0;
        rst_n   = 1'b1;
        start_v = '0;
        a       = '0;
        b       = '0;
        sub_s   = 1'b0;
        for (int k = 0; k < 3; k++) done_cnt[k] = 0;

        // Asynchronous reset with the clock stopped.
        #5 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy_v), 32'd0);
        check("reset_done", 32'(done_v), 32'd0);
        check("reset_sum0", 32'(sum0), 32'd0);
        check("reset_sum16", 32'(sum1), 32'd0);
        check("reset_sum1", 32'(sum2), 32'd0);
        #4 rst_n = 1'b1;
        clk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Carry ripples through every chunk; busy for exactly 4 sampled cycles.
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b1);
        bc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) seen = 1'b1;
            else if (busy_v[0] === 1'b1) bc++;
        end
        check("busy_cycles", 32'(bc), 32'd4);
        check("busy_low_at_done", 32'(busy_v[0]), 32'd0);

        // Back-to-back: start held during RUN is ignored, then accepted in the done cycle.
        issue(0, 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b1);
        @(negedge clk);
        a          = 16'hAAAA;
        b          = 16'h5555;
        start_v[0] = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) seen = 1'b1;
        end
        a = 16'h8000;
        b = 16'h8000;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("busy_b2b", 32'(busy_v[0]), 32'd1);
        sb.push_back('{id: 0, sum: 17'h10000, at_edge: cyc + 4});
        wait_done(0, 20);
        repeat (3) @(negedge clk);
        check("sum_hold", 32'(sum0), 32'h10000);
        check("no_extra_op", 32'(busy_v[0]), 32'd0);

        // Reset after E2 abandons the operation.
        issue(0, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_sum", 32'(sum0), 32'd0);
        check("midreset_busy", 32'(busy_v[0]), 32'd0);
        check("midreset_done", 32'(done_v[0]), 32'd0);
        dc = done_cnt[0];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midreset_no_done", 32'(done_cnt[0]), 32'(dc));
        issue(0, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b1);
        wait_done(0, 20);

        // Parameter corners.
        issue(1, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b1);
        wait_done(1, 5);
        issue(2, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b1);
        wait_done(2, 30);
        issue(2, 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b1);
        wait_done(2, 30);

`ifdef SEQ_ADDER_SUB_EN
        issue(0, 16'h0003, 16'h0005, 1'b1, 17'h1FFFE, 1'b1);
        wait_done(0, 20);
        issue(0, 16'h0005, 16'h0003, 1'b1, 17'h00002, 1'b1);
        wait_done(0, 20);
        issue(1, 16'h0003, 16'h0005, 1'b1, 17'h1FFFE, 1'b1);
        wait_done(1, 5);
        issue(2, 16'h0005, 16'h0003, 1'b1, 17'h00002, 1'b1);
        wait_done(2, 30);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b1);
        wait_done(0, 20);
`endif

        repeat (3) @(negedge clk);
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL missing_done dut%0d: got no done expected sum 0x%0h", sb[i].id, sb[i].sum);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

endmodule

// File: doc/seq_ripple_adder.md
# seq_ripple_adder

- Parametrised, multi-cycle successor to the team's fixed 5-bit combinational ripple adder.
- Adds two unsigned WIDTH-bit operands CHUNK bits per clock, rippling the carry between cycles through a carry register.
- Trades latency for a short critical path.
- Sits in the datapath behind a start/busy/done handshake, so a controller can launch operations and collect a WIDTH+1-bit result.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Derived: N = WIDTH/CHUNK, the cycles per operation.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only when busy=0.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- sub  in  1  subtract select; exists only with SEQ_ADDER_SUB_EN; sampled with the operands.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when sum holds a new result.
- sum  out  WIDTH+1  result; bit WIDTH is carry-out (or borrow, see Configuration).

## Operation
States:
- IDLE:
  - busy=0.
  - start=1 on an edge → latch a into opA and b into opB; clear carry to 0; clear chunk counter to 0; go to RUN.
  - start=0 → stay in IDLE.
- RUN:
  - busy=1.
  - Each edge computes {c, s} = opA[CHUNK-1:0] + opB[CHUNK-1:0] + carry.
  - opA and opB shift right by CHUNK.
  - s shifts into the top of the result register (LSB chunk enters first).
  - carry ← c; counter increments.
  - The edge processing chunk N-1 writes sum = {c, full result}, pulses done, and returns to IDLE.
- start during RUN is ignored; no queueing.
- Operand inputs may change freely after the accepting edge.
- sum holds its last value until the next completion. It is never partially updated; the working register is internal.
- Arithmetic is unsigned modulo 2^(WIDTH+1); no overflow condition exists in add mode.
- Reset (any time, including mid-RUN):
  - state=IDLE; busy=0; done=0; sum=0; all internal registers cleared.
  - The in-flight operation is abandoned; no done is produced for it.

## Timing
- Accepting edge = E0. busy rises after E0.
- Chunks are computed on edges E1..EN.
- After EN: sum is valid, done=1 for exactly one cycle, busy=0.
- Latency from start sampled to done asserted: N cycles. Throughput: one operation per N+1 cycles.
- Back-to-back: start=1 in the cycle where done=1 is accepted (busy=0 then); that operation's done follows N+1 edges after the previous one's.
- CHUNK=WIDTH: N=1, single-cycle operation with done one edge after acceptance.
- Critical path: one CHUNK-bit ripple plus the carry register.

## Configuration
- SEQ_ADDER_SUB_EN defined:
  - sub port exists.
  - sub=1 on the accepting edge → opB latched as ~b and initial carry=1, so the block computes a-b.
  - In subtract mode sum[WIDTH] = ~carry-out, i.e. borrow: 1 iff a<b unsigned.
  - sum[WIDTH-1:0] holds (a-b) mod 2^WIDTH.
  - sub=0 behaves exactly as the add-only build.
- SEQ_ADDER_SUB_EN undefined:
  - No sub port.
  - Initial carry always 0; add only.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- Reset: rst_n low mid-cycle with no clock → busy=0, done=0, sum=0 immediately.
- Carry through all chunks: a=0xFFFF, b=0x0001, start for one cycle → busy high 4 cycles; done pulse after the 4th edge; sum=0x10000.
- Back-to-back with ignored start:
  - a=0x1234, b=0x4321 → sum=0x05555.
  - start held high during RUN with a=0xAAAA is ignored.
  - start re-asserted in the done cycle with a=0x8000, b=0x8000 → sum=0x10000 exactly 5 edges after the first done.
- Reset mid-operation: rst_n pulled low after E2 of a=0xFFFF, b=0xFFFF → no done; sum=0. A fresh operation afterwards completes normally with sum=0x1FFFE.
- Parameter corners:
  - CHUNK=16: 0xFFFF+0xFFFF → done one edge after acceptance; sum=0x1FFFE.
  - CHUNK=1: done after 16 edges; same result.
- SEQ_ADDER_SUB_EN build:
  - 0x0003-0x0005 → sum=0x1FFFE (borrow=1).
  - 0x0005-0x0003 → sum=0x00002 (borrow=0).
  - sub=0 add cases match the add-only build.
